// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle LEGv8 core (fetch/decode/execute/mem/writeback sequencing)
//   in : clk, reset (async, active-high), op = IR[31:21], zero, imem_ready, dmem_ready
//   out: imem_req, dmem_req, mem_write, ir_write, pc_write, pc_src, reg2loc, alu_src, alu_ctrl,
//        reg_write, mem_to_reg, busy, trap (sticky), retired (wrapping instruction count)
module multicycle_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      op,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg2loc,
    output logic             alu_src,
    output logic [3:0]       alu_ctrl,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             busy,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] FETCH  = 4'd1;
    localparam logic [3:0] DECODE = 4'd2;
    localparam logic [3:0] EXEC_R = 4'd3;
    localparam logic [3:0] EXEC_I = 4'd4;
    localparam logic [3:0] WB_ALU = 4'd5;
    localparam logic [3:0] ADDR   = 4'd6;
    localparam logic [3:0] MEM_RD = 4'd7;
    localparam logic [3:0] WB_MEM = 4'd8;
    localparam logic [3:0] MEM_WR = 4'd9;
    localparam logic [3:0] BRANCH = 4'd10;
    localparam logic [3:0] TRAP   = 4'd11;

    logic [3:0]    state, nxt;
    logic [WW-1:0] wcnt;
    logic          is_stur, is_cbz, wait_to, waiting, retire;
    logic [3:0]    r_ctrl;

    assign is_stur = op == 11'b11111000000;
    assign is_cbz  = op[10:3] == 8'b10110100;
    assign wait_to = wcnt == WW'(TIMEOUT - 1);
    assign waiting = state == FETCH || state == MEM_RD || state == MEM_WR;
    assign retire  = state == WB_ALU || state == WB_MEM || state == BRANCH || (state == MEM_WR && dmem_ready);
    assign r_ctrl  = op == 11'b11001011000 ? 4'b0110 :
                     op == 11'b10001010000 ? 4'b0000 :
                     op == 11'b10101010000 ? 4'b0001 : 4'b0010;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:                   nxt = FETCH;
            FETCH:                  nxt = imem_ready ? DECODE : wait_to ? TRAP : FETCH;
            DECODE:
                casez (op)
                    11'b11111000010,
                    11'b11111000000:  nxt = ADDR;
                    11'b10110100???:  nxt = BRANCH;
                    11'b1001000100?,
                    11'b1101000100?:  nxt = EXEC_I;
                    11'b10001011000,
                    11'b11001011000,
                    11'b10001010000,
                    11'b10101010000:  nxt = EXEC_R;
                    default:          nxt = TRAP;
                endcase
            EXEC_R, EXEC_I:         nxt = WB_ALU;
            WB_ALU, WB_MEM, BRANCH: nxt = FETCH;
            ADDR:                   nxt = is_stur ? MEM_WR : MEM_RD;
            MEM_RD:                 nxt = dmem_ready ? WB_MEM : wait_to ? TRAP : MEM_RD;
            MEM_WR:                 nxt = dmem_ready ? FETCH : wait_to ? TRAP : MEM_WR;
            default:                nxt = TRAP;
        endcase
    end

    // wait counter restarts on every entry into a waiting state and counts only stalled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wcnt    <= '0;
            retired <= '0;
        end else begin
            state   <= nxt;
            wcnt    <= (waiting && nxt == state) ? wcnt + 1'b1 : '0;
            retired <= retired + CNT_W'(retire);
        end
    end

    assign imem_req   = state == FETCH;
    assign dmem_req   = state == MEM_RD || state == MEM_WR;
    assign mem_write  = state == MEM_WR;
    assign ir_write   = state == FETCH && imem_ready;
    assign pc_src     = state == BRANCH && zero;
    assign pc_write   = ir_write || pc_src;
    assign reg2loc    = (state == DECODE && (is_stur || is_cbz)) || (state == ADDR && is_stur) ||
                        state == MEM_WR || state == BRANCH;
    assign alu_src    = state == EXEC_I || state == ADDR;
    assign alu_ctrl   = state == EXEC_R ? r_ctrl :
                        state == EXEC_I ? (op[9] ? 4'b0110 : 4'b0010) :
                        state == ADDR   ? 4'b0010 :
                        state == BRANCH ? 4'b0111 : 4'b0000;
    assign reg_write  = state == WB_ALU || state == WB_MEM;
    assign mem_to_reg = state == WB_MEM;
    assign busy       = state != IDLE && state != TRAP;
    assign trap       = state == TRAP;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic        clk = 1'b0, reset = 1'b1;
    logic [10:0] op = '0;
    logic        zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        imem_req, dmem_req, mem_write, ir_write, pc_write, pc_src, reg2loc, alu_src;
    logic [3:0]  alu_ctrl;
    logic        reg_write, mem_to_reg, busy, trap;
    logic [31:0] retired;
    int          checks = 0, errors = 0;

    typedef struct packed { logic [15:0] c; logic [31:0] r; } exp_t;
    exp_t  sb[$];
    string tags[$];

    multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .busy(busy), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] cv(input logic ir, dr, mw, iw, pw, ps, rl, as,
                                       input logic [3:0] ac, input logic rw, mr, b, t);
        return {ir, dr, mw, iw, pw, ps, rl, as, ac, rw, mr, b, t};
    endfunction

    task automatic step(input logic ir_rdy, dr_rdy, z, input logic [10:0] o,
                        input logic [15:0] e, input logic [31:0] r, input string tag);
        exp_t x;
        string t;
        logic [15:0] got;
        imem_ready = ir_rdy;
        dmem_ready = dr_rdy;
        zero = z;
        op = o;
        sb.push_back('{c: e, r: r});
        tags.push_back(tag);
        @(negedge clk);
        x = sb.pop_front();
        t = tags.pop_front();
        got = {imem_req, dmem_req, mem_write, ir_write, pc_write, pc_src, reg2loc, alu_src,
               alu_ctrl, reg_write, mem_to_reg, busy, trap};
        checks++;
        assert ({got, retired} === {x.c, x.r}) else begin
            errors++;
            $error("FAIL %s ctrl=%h retired=%0d expected ctrl=%h retired=%0d", t, got, retired, x.c, x.r);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] s_idle, f_ok, f_wait, dec, dec_r2, ex_add, ex_sub, ex_orr, ex_addi, ex_subi;
        logic [15:0] wb_alu, adr_ld, adr_st, mrd, wb_mem, mwr, br_t, br_n, s_trap;
        logic [10:0] ADD = 11'b10001011000, LDUR = 11'b11111000010, STUR = 11'b11111000000;
        logic [10:0] CBZ = 11'b10110100101, SUBI = 11'b11010001001, ORR = 11'b10101010000;
        logic [10:0] ADDI = 11'b10010001000, BAD = 11'b00000000000;
        s_idle  = cv(0,0,0,0,0,0,0,0,4'b0000,0,0,0,0);
        f_ok    = cv(1,0,0,1,1,0,0,0,4'b0000,0,0,1,0);
        f_wait  = cv(1,0,0,0,0,0,0,0,4'b0000,0,0,1,0);
        dec     = cv(0,0,0,0,0,0,0,0,4'b0000,0,0,1,0);
        dec_r2  = cv(0,0,0,0,0,0,1,0,4'b0000,0,0,1,0);
        ex_add  = cv(0,0,0,0,0,0,0,0,4'b0010,0,0,1,0);
        ex_orr  = cv(0,0,0,0,0,0,0,0,4'b0001,0,0,1,0);
        ex_sub  = cv(0,0,0,0,0,0,0,0,4'b0110,0,0,1,0);
        ex_addi = cv(0,0,0,0,0,0,0,1,4'b0010,0,0,1,0);
        ex_subi = cv(0,0,0,0,0,0,0,1,4'b0110,0,0,1,0);
        wb_alu  = cv(0,0,0,0,0,0,0,0,4'b0000,1,0,1,0);
        adr_ld  = cv(0,0,0,0,0,0,0,1,4'b0010,0,0,1,0);
        adr_st  = cv(0,0,0,0,0,0,1,1,4'b0010,0,0,1,0);
        mrd     = cv(0,1,0,0,0,0,0,0,4'b0000,0,0,1,0);
        wb_mem  = cv(0,0,0,0,0,0,0,0,4'b0000,1,1,1,0);
        mwr     = cv(0,1,1,0,0,0,1,0,4'b0000,0,0,1,0);
        br_t    = cv(0,0,0,0,1,1,1,0,4'b0111,0,0,1,0);
        br_n    = cv(0,0,0,0,0,0,1,0,4'b0111,0,0,1,0);
        s_trap  = cv(0,0,0,0,0,0,0,0,4'b0000,0,0,0,1);

        step(1, 0, 0, ADD, s_idle, 0, "reset_held");
        reset = 1'b0;
        step(1, 0, 0, ADD, s_idle, 0, "idle");
        step(1, 0, 0, ADD, f_ok, 0, "add_fetch");
        step(1, 0, 0, ADD, dec, 0, "add_decode");
        step(1, 0, 0, ADD, ex_add, 0, "add_exec");
        step(1, 0, 0, ADD, wb_alu, 0, "add_wb");
        step(1, 0, 0, LDUR, f_ok, 1, "ldur_fetch");
        step(1, 0, 0, LDUR, dec, 1, "ldur_decode");
        step(1, 0, 0, LDUR, adr_ld, 1, "ldur_addr");
        for (int i = 0; i < 3; i++) step(1, 0, 0, LDUR, mrd, 1, "ldur_wait");
        step(1, 1, 0, LDUR, mrd, 1, "ldur_rdy");
        step(1, 0, 0, LDUR, wb_mem, 1, "ldur_wb");
        step(1, 0, 1, CBZ, f_ok, 2, "cbz1_fetch");
        step(1, 0, 1, CBZ, dec_r2, 2, "cbz1_decode");
        step(1, 0, 1, CBZ, br_t, 2, "cbz1_taken");
        step(1, 0, 0, CBZ, f_ok, 3, "cbz2_fetch");
        step(1, 0, 0, CBZ, dec_r2, 3, "cbz2_decode");
        step(1, 0, 0, CBZ, br_n, 3, "cbz2_not_taken");
        step(1, 0, 0, STUR, f_ok, 4, "stur_fetch");
        step(1, 0, 0, STUR, dec_r2, 4, "stur_decode");
        step(1, 0, 0, STUR, adr_st, 4, "stur_addr");
        step(1, 1, 0, STUR, mwr, 4, "stur_mem");
        step(1, 0, 0, SUBI, f_ok, 5, "subi_fetch");
        step(1, 0, 0, SUBI, dec, 5, "subi_decode");
        step(1, 0, 0, SUBI, ex_subi, 5, "subi_exec");
        step(1, 0, 0, SUBI, wb_alu, 5, "subi_wb");
        step(1, 0, 0, ORR, f_ok, 6, "orr_fetch");
        step(1, 0, 0, ORR, dec, 6, "orr_decode");
        step(1, 0, 0, ORR, ex_orr, 6, "orr_exec");
        step(1, 0, 0, ORR, wb_alu, 6, "orr_wb");
        for (int i = 0; i < 15; i++) step(0, 1, 0, ADDI, f_wait, 7, "fetch_wait");
        step(1, 0, 0, ADDI, f_ok, 7, "fetch_rdy_16th");
        step(1, 0, 0, ADDI, dec, 7, "addi_decode");
        step(1, 0, 0, ADDI, ex_addi, 7, "addi_exec");
        step(1, 0, 0, ADDI, wb_alu, 7, "addi_wb");
        for (int i = 0; i < 16; i++) step(0, 0, 0, ADD, f_wait, 8, "fetch_stuck");
        for (int i = 0; i < 3; i++) step(1, 1, 1, ADD, s_trap, 8, "timeout_trap");

        reset = 1'b1;
        step(1, 0, 0, STUR, s_idle, 0, "reset_from_trap");
        reset = 1'b0;
        step(1, 0, 0, STUR, s_idle, 0, "idle2");
        step(1, 0, 0, STUR, f_ok, 0, "stur2_fetch");
        step(1, 0, 0, STUR, dec_r2, 0, "stur2_decode");
        step(1, 0, 0, STUR, adr_st, 0, "stur2_addr");
        step(1, 0, 0, STUR, mwr, 0, "stur2_wait");
        reset = 1'b1;
        #1;
        checks++;
        assert ({dmem_req, imem_req, busy, retired} === {1'b0, 1'b0, 1'b0, 32'd0}) else begin
            errors++;
            $error("FAIL async_reset dmem_req=%b busy=%b retired=%0d expected 0 0 0", dmem_req, busy, retired);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1, 0, 0, BAD, s_idle, 0, "idle3");
        step(1, 0, 0, BAD, f_ok, 0, "bad_fetch");
        step(1, 0, 0, BAD, dec, 0, "bad_decode");
        for (int i = 0; i < 4; i++) step(1, 1, 1, ADD, s_trap, 0, "bad_trap");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
